// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: turns debounced key pulses into a heading and a pause state.
// Valid turns are queued and applied one per game step, so quick double presses are kept.
module snake_dir_ctrl #(
    parameter int         QDEPTH  = 2,
    parameter logic [1:0] RST_DIR = 2'b11
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       key_up_flag,
    input  logic       key_down_flag,
    input  logic       key_left_flag,
    input  logic       key_right_flag,
    input  logic       key_pause_flag,
    input  logic       step_tick,
    input  logic       game_over,
    output logic [1:0] dir,
    output logic       paused,
    output logic       turn_strobe,
    output logic [2:0] q_count
);

    localparam int            PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW-1:0] LAST  = PW'(QDEPTH - 1);
    localparam logic [2:0]    QFULL = 3'(QDEPTH);

    logic [1:0]    mem_q [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    dir_q, dir_d;
    logic          paused_q, paused_d;
    logic          strobe_q, strobe_d;

    logic          cand_vld;
    logic [1:0]    cand;
    logic [PW-1:0] tail_ptr;
    logic [1:0]    ref_dir;
    logic          pause_tgl;
    logic          flush;
    logic          pop;
    logic          push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        cand_vld = key_up_flag | key_down_flag | key_left_flag | key_right_flag;
        if (key_up_flag)        cand = 2'b00;
        else if (key_down_flag) cand = 2'b01;
        else if (key_left_flag) cand = 2'b10;
        else                    cand = 2'b11;

        // Validate against the newest queued turn so chained presses stay legal.
        tail_ptr = (wr_ptr_q == '0) ? LAST : wr_ptr_q - PW'(1);
        ref_dir  = (cnt_q != 3'd0) ? mem_q[tail_ptr] : dir_q;

        pause_tgl = key_pause_flag & ~game_over;
        flush     = game_over | (pause_tgl & ~paused_q);
        pop       = step_tick & ~paused_q & ~game_over & ~pause_tgl & (cnt_q != 3'd0);
        push      = cand_vld & ~paused_q & ~flush
                  & (cand != ref_dir) & (cand != (ref_dir ^ 2'b01))
                  & ((cnt_q != QFULL) | pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = 3'd0;
        end else begin
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            cnt_d = cnt_q + 3'(push) - 3'(pop);
        end

        dir_d    = pop ? mem_q[rd_ptr_q] : dir_q;
        strobe_d = pop;
        paused_d = game_over ? 1'b0 : (paused_q ^ key_pause_flag);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= 3'd0;
            dir_q    <= RST_DIR;
            paused_q <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            paused_q <= paused_d;
            strobe_q <= strobe_d;
        end
    end

    // Queue storage carries data only; occupancy is tracked by cnt_q.
    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_ptr_q] <= cand;
    end

    assign dir         = dir_q;
    assign paused      = paused_q;
    assign turn_strobe = strobe_q;
    assign q_count     = cnt_q;

endmodule
